coletor_medidas: RTL and testbench
==================================

Name: coletor_medidas

Overview:
Upstream stage of classificador_medida. On a start request it takes three consecutive readings from the sensor front-end, spacing them by a programmable interval, and stores them as medida1..medida3. It then clears the classifier, launches it, and waits for fim_classificacao. A sensor timeout aborts the cycle with a sticky error flag.

Parameters:
- WIDTH, 12, width of each reading and of medida1..3.
- INTERVALO, 50000, idle clock cycles between the end of one reading and the next medir pulse (>=1).
- TIMEOUT, 1000000, maximum cycles to wait for medida_pronto after medir (>=2).

Ports:
- clock  in  1  system clock, rising edge.
- zera_n  in  1  asynchronous active-low reset.
- iniciar_ciclo  in  1  starts a 3-reading cycle; honoured only in OCIOSO.
- medida_pronto  in  1  sensor reading valid, one-cycle pulse.
- medida_in  in  WIDTH  sensor reading, valid when medida_pronto=1.
- fim_classificacao  in  1  classifier done (level; cleared only by the classifier's zera).
- medir  out  1  one-cycle trigger to the sensor.
- medida1, medida2, medida3  out  WIDTH each  stored readings; feed the classifier directly.
- zera_classificador  out  1  one-cycle active-high clear to the classifier.
- iniciar_classificacao  out  1  one-cycle start to the classifier.
- ocupado  out  1  high in every state except OCIOSO.
- ciclo_concluido  out  1  one-cycle pulse when the classifier reports done.
- erro_timeout  out  1  sticky; set on sensor timeout, cleared when the next cycle starts.

Behaviour:
- Reset (zera_n=0, async): state=OCIOSO, idx=0, timer=0. All outputs are 0, including medida1..3.
- All outputs are registered.
- OCIOSO: if iniciar_ciclo=1, the next edge does all of the following:
  - clears erro_timeout and medida1..3;
  - sets idx=0 and asserts zera_classificador for exactly 1 cycle;
  - goes to DISPARA.
- DISPARA: medir=1 for exactly 1 cycle, timer=0, then ESPERA.
- ESPERA: timer increments every cycle.
  - medida_pronto=1: the reading is written to medida[idx+1] on that edge. If idx=2, go to ENTREGA; otherwise go to PAUSA with timer=0.
  - No medida_pronto by timer=TIMEOUT-1: go to ERRO. A pronto in that same cycle wins over the timeout.
- PAUSA: counts INTERVALO cycles. On the last cycle, idx increments and the state goes to DISPARA. Latency from pronto to the next medir is INTERVALO+1 cycles.
- ENTREGA: iniciar_classificacao=1 for exactly 1 cycle, then AGUARDA_FIM. medida1..3 are stable from ENTREGA until the next cycle starts.
- AGUARDA_FIM: on fim_classificacao=1, ciclo_concluido=1 for 1 cycle and the state returns to OCIOSO.
  - No timeout here: the classifier answers in a fixed 2 cycles.
  - fim is ignored in every other state.
- ERRO: sets erro_timeout=1, holds medida1..3, and returns to OCIOSO next cycle. ciclo_concluido is not pulsed.
- Ignored inputs:
  - iniciar_ciclo outside OCIOSO; no queuing.
  - medida_pronto outside ESPERA; dropped.
  - A pronto arriving in the same cycle as medir: it is not yet ESPERA, so it is dropped.
- Reset mid-cycle returns to OCIOSO immediately with all outputs 0. The classifier's own reset handles its side.
- The timer is $clog2(max(TIMEOUT,INTERVALO)+1) bits and never wraps, because it is cleared at each state entry.
- Readings are stored unmodified with no arithmetic. Range checks are the classifier's job.

Decomposition:
- Package coletor_pkg holds:
  - the state encoding (OCIOSO, DISPARA, ESPERA, PAUSA, ENTREGA, AGUARDA_FIM, ERRO), 3 bits;
  - the idx width (2);
  - the last-index constant (2).
- One natural sub-module: contador_limite, a clearable up-counter with an enable and a "reached limit" output. It is shared by the ESPERA timeout and the PAUSA interval.
- The FSM and storage registers stay in the top module.

Test Plan:
Bench uses INTERVALO=4, TIMEOUT=10.
- Nominal: iniciar_ciclo, sensor answers 3 cycles after each medir with 0x014, 0x016, 0x015 -> medida1..3=0x014/0x016/0x015, exactly 3 medir pulses each 5 cycles after the previous pronto, one iniciar_classificacao; fim raised 2 cycles later -> ciclo_concluido pulse, ocupado=0.
- Timeout: sensor silent after the 2nd medir -> erro_timeout=1 10 cycles after ESPERA entry, state OCIOSO, medida1=first reading, no iniciar_classificacao. Then a new iniciar_ciclo -> erro_timeout=0 and medida1..3=0.
- Boundary: pronto exactly at timer=TIMEOUT-1 -> reading accepted, erro_timeout stays 0; pronto one cycle later -> error.
- Spurious inputs: iniciar_ciclo during PAUSA and pronto during PAUSA/OCIOSO -> no state change, medida regs unchanged, no extra medir.
- Classifier hookup: instantiate classificador_medida, readings 0x020/0x021/0x022 -> zera_classificador pulse at start, classifier media=0x021, descartar=0, ciclo_concluido fires once; a second run does not conclude early on a stale fim.
- Reset mid-ESPERA: drop zera_n asynchronously -> all outputs 0 immediately, medir never re-asserted until a new iniciar_ciclo.

Source files
------------

// File: rtl/coletor_pkg.sv
// Shared definitions for the three-reading measurement collector.
`default_nettype none

package coletor_pkg;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        DISPARA     = 3'd1,
        ESPERA      = 3'd2,
        PAUSA       = 3'd3,
        ENTREGA     = 3'd4,
        AGUARDA_FIM = 3'd5,
        ERRO        = 3'd6
    } estado_t;

    localparam int             IDX_W      = 2;
    localparam logic [IDX_W-1:0] ULTIMO_IDX = 2'd2;

endpackage

`default_nettype wire

// File: rtl/contador_limite.sv
// Clearable up-counter with enable; flags when the count equals a limit.
`default_nettype none

module contador_limite #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             limpar,
    input  logic             habilitar,
    input  logic [WIDTH-1:0] limite,
    output logic             atingiu
);

    logic [WIDTH-1:0] r_contagem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contagem <= '0;
        end else if (limpar) begin
            r_contagem <= '0;
        end else if (habilitar) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    assign atingiu = (r_contagem == limite);

endmodule

`default_nettype wire

// File: rtl/coletor_medidas.sv
// Takes three spaced sensor readings, then clears and launches the classifier.
`default_nettype none

module coletor_medidas
    import coletor_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int INTERVALO = 50000,
    parameter int TIMEOUT   = 1000000
) (
    input  logic             clock,
    input  logic             zera_n,
    input  logic             iniciar_ciclo,
    input  logic             medida_pronto,
    input  logic [WIDTH-1:0] medida_in,
    input  logic             fim_classificacao,
    output logic             medir,
    output logic [WIDTH-1:0] medida1,
    output logic [WIDTH-1:0] medida2,
    output logic [WIDTH-1:0] medida3,
    output logic             zera_classificador,
    output logic             iniciar_classificacao,
    output logic             ocupado,
    output logic             ciclo_concluido,
    output logic             erro_timeout
);

    localparam int MAX_CONT = (TIMEOUT > INTERVALO) ? TIMEOUT : INTERVALO;
    localparam int TW       = $clog2(MAX_CONT + 1);
    localparam logic [TW-1:0] LIM_ESPERA = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] LIM_PAUSA  = TW'(INTERVALO - 1);

    estado_t          r_estado;
    logic [IDX_W-1:0] r_idx;
    logic             w_limpar;
    logic             w_habilitar;
    logic [TW-1:0]    w_limite;
    logic             w_atingiu;

    // One timer serves both waits; any state change or accepted reading restarts it.
    assign w_habilitar = (r_estado == ESPERA) || (r_estado == PAUSA);
    assign w_limpar    = !w_habilitar || ((r_estado == ESPERA) && medida_pronto);
    assign w_limite    = (r_estado == PAUSA) ? LIM_PAUSA : LIM_ESPERA;

    contador_limite #(
        .WIDTH (TW)
    ) u_timer (
        .clk       (clock),
        .rst_n     (zera_n),
        .limpar    (w_limpar),
        .habilitar (w_habilitar),
        .limite    (w_limite),
        .atingiu   (w_atingiu)
    );

    always_ff @(posedge clock or negedge zera_n) begin
        if (!zera_n) begin
            r_estado              <= OCIOSO;
            r_idx                 <= '0;
            medir                 <= 1'b0;
            medida1               <= '0;
            medida2               <= '0;
            medida3               <= '0;
            zera_classificador    <= 1'b0;
            iniciar_classificacao <= 1'b0;
            ocupado               <= 1'b0;
            ciclo_concluido       <= 1'b0;
            erro_timeout          <= 1'b0;
        end else begin
            medir                 <= 1'b0;
            zera_classificador    <= 1'b0;
            iniciar_classificacao <= 1'b0;
            ciclo_concluido       <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (iniciar_ciclo) begin
                        erro_timeout       <= 1'b0;
                        medida1            <= '0;
                        medida2            <= '0;
                        medida3            <= '0;
                        r_idx              <= '0;
                        zera_classificador <= 1'b1;
                        medir              <= 1'b1;
                        ocupado            <= 1'b1;
                        r_estado           <= DISPARA;
                    end
                end
                DISPARA: r_estado <= ESPERA;
                ESPERA: begin
                    // An accepted reading takes priority over a timeout on the same cycle.
                    if (medida_pronto) begin
                        case (r_idx)
                            2'd0:    medida1 <= medida_in;
                            2'd1:    medida2 <= medida_in;
                            default: medida3 <= medida_in;
                        endcase
                        if (r_idx == ULTIMO_IDX) begin
                            iniciar_classificacao <= 1'b1;
                            r_estado              <= ENTREGA;
                        end else begin
                            r_estado <= PAUSA;
                        end
                    end else if (w_atingiu) begin
                        erro_timeout <= 1'b1;
                        r_estado     <= ERRO;
                    end
                end
                PAUSA: begin
                    if (w_atingiu) begin
                        r_idx    <= r_idx + 1'b1;
                        medir    <= 1'b1;
                        r_estado <= DISPARA;
                    end
                end
                ENTREGA: r_estado <= AGUARDA_FIM;
                AGUARDA_FIM: begin
                    if (fim_classificacao) begin
                        ciclo_concluido <= 1'b1;
                        ocupado         <= 1'b0;
                        r_estado        <= OCIOSO;
                    end
                end
                ERRO: begin
                    ocupado  <= 1'b0;
                    r_estado <= OCIOSO;
                end
                default: begin
                    ocupado  <= 1'b0;
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_coletor_medidas.sv
// Bench for coletor_medidas: vector table, random transactions, reset corner cases.
`default_nettype none

module tb_coletor_medidas;

    localparam int W         = 12;
    localparam int INTERVALO = 4;
    localparam int TIMEOUT   = 10;

    logic         clock = 1'b0;
    logic         zera_n = 1'b0;
    logic         iniciar_ciclo = 1'b0;
    logic         medida_pronto = 1'b0;
    logic [W-1:0] medida_in = '0;
    logic         fim_classificacao = 1'b0;
    logic         medir;
    logic [W-1:0] medida1, medida2, medida3;
    logic         zera_classificador, iniciar_classificacao, ocupado, ciclo_concluido, erro_timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_medir = 0;
    int n_inic = 0;
    int n_conc = 0;
    int cls_cnt = 0;

    coletor_medidas #(
        .WIDTH     (W),
        .INTERVALO (INTERVALO),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock                 (clock),
        .zera_n                (zera_n),
        .iniciar_ciclo         (iniciar_ciclo),
        .medida_pronto         (medida_pronto),
        .medida_in             (medida_in),
        .fim_classificacao     (fim_classificacao),
        .medir                 (medir),
        .medida1               (medida1),
        .medida2               (medida2),
        .medida3               (medida3),
        .zera_classificador    (zera_classificador),
        .iniciar_classificacao (iniciar_classificacao),
        .ocupado               (ocupado),
        .ciclo_concluido       (ciclo_concluido),
        .erro_timeout          (erro_timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse counters and a classifier stand-in: fim rises 2 cycles after start, level until zera.
    always @(negedge clock) begin
        if (medir) n_medir <= n_medir + 1;
        if (iniciar_classificacao) n_inic <= n_inic + 1;
        if (ciclo_concluido) n_conc <= n_conc + 1;
        if (zera_classificador) begin
            fim_classificacao <= 1'b0;
            cls_cnt           <= 0;
        end else if (iniciar_classificacao) begin
            cls_cnt <= 2;
        end else if (cls_cnt > 0) begin
            cls_cnt <= cls_cnt - 1;
            if (cls_cnt == 1) fim_classificacao <= 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    typedef struct {
        logic [W-1:0] v0, v1, v2;
        int           d0, d1, d2;
        bit           spur;
        bit           e_erro;
        logic [W-1:0] e1, e2, e3;
    } vetor_t;

    vetor_t tab[7];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    // Transaction-level reference: readings are kept in order until the first one
    // whose response delay falls outside 1..TIMEOUT cycles after medir.
    function automatic void modelo(inout vetor_t t);
        int  d[3];
        bit  ok;
        d[0] = t.d0; d[1] = t.d1; d[2] = t.d2;
        t.e1 = '0; t.e2 = '0; t.e3 = '0; t.e_erro = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (ok && d[k] >= 1 && d[k] <= TIMEOUT) begin
                if (k == 0) t.e1 = t.v0;
                if (k == 1) t.e2 = t.v1;
                if (k == 2) t.e3 = t.v2;
            end else if (ok) begin
                ok = 1'b0;
                t.e_erro = 1'b1;
            end
        end
    endfunction

    // d = cycles from the medir cycle to the pronto cycle (0 means same cycle as medir).
    task automatic ciclo(input vetor_t t, input string nome);
        logic [W-1:0] v[3];
        logic [W-1:0] got;
        int d[3];
        int m0, i0, c0, M, P, lidas, lim;
        bit abort, found, acc;
        v[0] = t.v0; v[1] = t.v1; v[2] = t.v2;
        d[0] = t.d0; d[1] = t.d1; d[2] = t.d2;
        m0 = n_medir; i0 = n_inic; c0 = n_conc;
        abort = 1'b0; lidas = 0; P = 0; M = 0;

        iniciar_ciclo = 1'b1;
        tick;
        iniciar_ciclo = 1'b0;
        chk({nome, ".zera"}, 32'(zera_classificador), 1);
        chk({nome, ".medir0"}, 32'(medir), 1);
        chk({nome, ".ocupado"}, 32'(ocupado), 1);
        chk({nome, ".erro_limpo"}, 32'(erro_timeout), 0);
        chk({nome, ".m_limpas"}, 32'({medida1, medida2, medida3}), 0);
        M = cyc;

        for (int k = 0; k < 3; k++) begin
            if (!abort && k > 0) begin
                found = 1'b0;
                for (int w = 0; w < INTERVALO + 4 && !found; w++) begin
                    if (t.spur && k == 1 && w == 0) begin
                        iniciar_ciclo = 1'b1;
                        medida_pronto = 1'b1;
                        medida_in     = ~v[0];
                    end
                    tick;
                    iniciar_ciclo = 1'b0;
                    medida_pronto = 1'b0;
                    found = medir;
                end
                chk({nome, ".medir_gap"}, found ? 32'(cyc - P) : 32'hDEAD, 32'(INTERVALO + 1));
                if (!found) abort = 1'b1;
                M = cyc;
            end
            if (!abort) begin
                acc = (d[k] >= 1 && d[k] <= TIMEOUT);
                lim = acc ? d[k] : TIMEOUT + 1;
                for (int c = 0; c <= lim; c++) begin
                    medida_pronto = (c == d[k]);
                    medida_in     = v[k];
                    tick;
                    if (!acc && c == TIMEOUT - 1) chk({nome, ".erro_cedo"}, 32'(erro_timeout), 0);
                    if (!acc && c == TIMEOUT)     chk({nome, ".erro_lat"}, 32'(erro_timeout), 1);
                end
                medida_pronto = 1'b0;
                if (acc) begin
                    P = cyc - 1;
                    lidas++;
                    got = (k == 0) ? medida1 : (k == 1) ? medida2 : medida3;
                    chk({nome, ".leitura"}, 32'(got), 32'(v[k]));
                    if (k == 2) chk({nome, ".inicia_cls"}, 32'(iniciar_classificacao), 1);
                end else begin
                    abort = 1'b1;
                    chk({nome, ".ocioso_pos_erro"}, 32'(ocupado), 0);
                end
            end
        end

        if (!abort) begin
            found = 1'b0;
            for (int w = 0; w < 8 && !found; w++) begin
                tick;
                found = ciclo_concluido;
            end
            chk({nome, ".lat_concluido"}, found ? 32'(cyc - (P + 1)) : 32'hDEAD, 3);
            tick;
            chk({nome, ".ocupado_fim"}, 32'(ocupado), 0);
        end else begin
            repeat (2) tick;
        end

        chk({nome, ".n_medir"}, 32'(n_medir - m0), abort ? 32'(lidas + 1) : 32'd3);
        chk({nome, ".n_inicia"}, 32'(n_inic - i0), abort ? 32'd0 : 32'd1);
        chk({nome, ".n_concluido"}, 32'(n_conc - c0), abort ? 32'd0 : 32'd1);
        chk({nome, ".m1"}, 32'(medida1), 32'(t.e1));
        chk({nome, ".m2"}, 32'(medida2), 32'(t.e2));
        chk({nome, ".m3"}, 32'(medida3), 32'(t.e3));
        chk({nome, ".erro"}, 32'(erro_timeout), 32'(t.e_erro));
    endtask

    initial begin
        vetor_t r;
        int m0;

        tab[0] = '{12'h014, 12'h016, 12'h015,  3,  3,  3, 1'b0, 1'b0, 12'h014, 12'h016, 12'h015};
        tab[1] = '{12'h0AB, 12'h0CD, 12'h0EF,  3, 50,  3, 1'b0, 1'b1, 12'h0AB, 12'h000, 12'h000};
        tab[2] = '{12'h111, 12'h222, 12'h333, 10, 10, 10, 1'b0, 1'b0, 12'h111, 12'h222, 12'h333};
        tab[3] = '{12'h444, 12'h555, 12'h666,  2, 11,  2, 1'b0, 1'b1, 12'h444, 12'h000, 12'h000};
        tab[4] = '{12'h7A1, 12'h7A2, 12'h7A3,  2,  5,  1, 1'b1, 1'b0, 12'h7A1, 12'h7A2, 12'h7A3};
        tab[5] = '{12'h123, 12'h456, 12'h789,  0,  3,  3, 1'b0, 1'b1, 12'h000, 12'h000, 12'h000};
        tab[6] = '{12'h020, 12'h021, 12'h022,  3,  3,  3, 1'b0, 1'b0, 12'h020, 12'h021, 12'h022};

        repeat (3) tick;
        chk("reset.medir", 32'(medir), 0);
        chk("reset.ocupado", 32'(ocupado), 0);
        chk("reset.medidas", 32'({medida1, medida2, medida3}), 0);
        chk("reset.pulsos", 32'({zera_classificador, iniciar_classificacao, ciclo_concluido, erro_timeout}), 0);
        zera_n = 1'b1;
        tick;

        for (int i = 0; i < 7; i++) ciclo(tab[i], $sformatf("vet%0d", i));

        chk("cls.media", 32'((32'(medida1) + 32'(medida2) + 32'(medida3)) / 3), 32'h021);

        // Pronto while idle must be dropped.
        m0 = n_medir;
        medida_pronto = 1'b1;
        medida_in     = 12'hFFF;
        tick;
        medida_pronto = 1'b0;
        repeat (2) tick;
        chk("ocioso.m1", 32'(medida1), 32'h020);
        chk("ocioso.ocupado", 32'(ocupado), 0);
        chk("ocioso.n_medir", 32'(n_medir - m0), 0);

        for (int i = 0; i < 12; i++) begin
            r.v0 = 12'($urandom);
            r.v1 = 12'($urandom);
            r.v2 = 12'($urandom);
            r.d0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 3)) : int'($urandom_range(1, TIMEOUT));
            r.d1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 3)) : int'($urandom_range(1, TIMEOUT));
            r.d2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT + 3)) : int'($urandom_range(1, TIMEOUT));
            r.spur = 1'($urandom_range(0, 1));
            modelo(r);
            ciclo(r, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of the second wait.
        iniciar_ciclo = 1'b1;
        tick;
        iniciar_ciclo = 1'b0;
        repeat (2) tick;
        medida_pronto = 1'b1;
        medida_in     = 12'h5A5;
        tick;
        medida_pronto = 1'b0;
        chk("rst.m1_antes", 32'(medida1), 32'h5A5);
        repeat (4) tick;
        chk("rst.medir2", 32'(medir), 1);
        repeat (2) tick;
        #3 zera_n = 1'b0;
        #1;
        chk("rst.m1", 32'(medida1), 0);
        chk("rst.ocupado", 32'(ocupado), 0);
        chk("rst.saidas", 32'({medir, zera_classificador, iniciar_classificacao, ciclo_concluido, erro_timeout}), 0);
        m0 = n_medir;
        #2 zera_n = 1'b1;
        repeat (20) tick;
        chk("rst.sem_medir", 32'(n_medir - m0), 0);
        chk("rst.ocioso", 32'(ocupado), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
